// File: rtl/synth_pkg.sv
// Shared definitions for the PWM sample scheduler slice.
//   DEFAULT_SAMPLE_W   : default sample / duty width
//   DEFAULT_IDLE_LEVEL : default duty while not running (midscale)
//   sample_t           : sample word at the default width
//   sched_state_t      : scheduler states IDLE / PRIME / RUN
package synth_pkg;

  localparam int DEFAULT_SAMPLE_W   = 8;
  localparam int DEFAULT_IDLE_LEVEL = 128;

  typedef logic [DEFAULT_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } sched_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with push/pop, flush and an occupancy counter.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   flush      : empties the FIFO on the next edge; wins over a same-cycle push
//   push       : write push_data (ignored while full)
//   push_data  : data to write
//   pop        : advance the read pointer (ignored while empty)
//   head       : oldest entry; a pushed word shows up here one cycle later
//   full       : registered full flag, so a pop does not free a slot until the next cycle
//   empty      : occupancy is zero
//   level      : current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_next;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full && !flush && !rst;
  assign pop_ok  = pop && !empty && !flush;
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  // Occupancy after this edge; drives the registered full flag.
  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_next = level - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == LEVEL_W'(DEPTH));
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Sequencing controller in front of the PWM comparator. Buffers samples,
// owns the frame counter and loads a new duty only at frame boundaries.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   en            : run enable
//   in_sample     : sample from producer, accepted when in_valid && in_ready
//   in_valid      : in_sample valid
//   in_ready      : FIFO not full
//   underrun_clr  : clears the sticky underrun flag
//   duty          : registered duty to the comparator
//   count         : registered frame counter (comparator high while count < duty)
//   frame_start   : high while count==0 in RUN
//   underrun      : sticky, a frame boundary found the FIFO empty
//   fifo_level    : FIFO occupancy
module pwm_sample_scheduler
  import synth_pkg::*;
#(
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int IDLE_LEVEL  = DEFAULT_IDLE_LEVEL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          underrun_clr,
  output logic [SAMPLE_W-1:0]           duty,
  output logic [SAMPLE_W-1:0]           count,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SAMPLE_W-1:0] IDLE_DUTY = SAMPLE_W'(IDLE_LEVEL);
  localparam logic [SAMPLE_W-1:0] COUNT_MAX = {SAMPLE_W{1'b1}};

  sched_state_t        state;
  sched_state_t        state_next;
  logic [SAMPLE_W-1:0] count_next;
  logic [SAMPLE_W-1:0] duty_next;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                flush;
  logic                set_underrun;

  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign frame_start = (state == RUN) && (count == '0);

  sample_fifo #(
    .WIDTH(SAMPLE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_sample),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state and datapath control. Dropping en in RUN takes priority over
  // a frame boundary and flushes the FIFO, discarding any same-cycle push.
  always_comb begin
    state_next   = state;
    count_next   = count;
    duty_next    = duty;
    pop          = 1'b0;
    flush        = 1'b0;
    set_underrun = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        duty_next  = IDLE_DUTY;
        if (en) state_next = PRIME;
      end
      PRIME: begin
        count_next = '0;
        duty_next  = IDLE_DUTY;
        if (!en) begin
          state_next = IDLE;
        end else if (fifo_level >= LEVEL_W'(PRIME_LEVEL)) begin
          state_next = RUN;
          pop        = 1'b1;
          duty_next  = fifo_head;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          count_next = '0;
          duty_next  = IDLE_DUTY;
          flush      = 1'b1;
        end else begin
          count_next = count + 1'b1;
          if (count == COUNT_MAX) begin
            if (!fifo_empty) begin
              pop       = 1'b1;
              duty_next = fifo_head;
            end else begin
              set_underrun = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter, duty and sticky underrun; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      duty     <= IDLE_DUTY;
      underrun <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      duty  <= duty_next;
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Self-checking bench for pwm_sample_scheduler: a reset/backpressure vector
// table, then hand sequences for priming, underrun, collision, disable and
// reset. A behavioural model with a sample queue runs alongside every cycle.
module tb_pwm_sample_scheduler;
  import synth_pkg::*;

  localparam int DEPTH     = 4;
  localparam int PRIME_LVL = 2;
  localparam int IDLE_DUTY = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in_sample;
  logic       in_valid;
  logic       in_ready;
  logic       underrun_clr;
  logic [7:0] duty;
  logic [7:0] count;
  logic       frame_start;
  logic       underrun;
  logic [2:0] fifo_level;

  int tests = 0;
  int fails = 0;

  sched_state_t mState = IDLE;
  int           mCount = 0;
  int           mDuty  = IDLE_DUTY;
  bit           mUnder = 1'b0;
  int           expQ[$];

  typedef struct {
    bit      rst;
    bit      en;
    bit      valid;
    sample_t sample;
    bit      clr;
    int      eDuty;
    int      eCount;
    int      eReady;
    int      eLevel;
    int      eUnder;
    int      eFs;
  } vec_t;

  vec_t vecs[11];

  pwm_sample_scheduler #(
    .SAMPLE_W(8),
    .FIFO_DEPTH(DEPTH),
    .PRIME_LEVEL(PRIME_LVL),
    .IDLE_LEVEL(IDLE_DUTY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .underrun_clr (underrun_clr),
    .duty         (duty),
    .count        (count),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [7:0] s, input bit c);
    rst          = r;
    en           = e;
    in_valid     = v;
    in_sample    = s;
    underrun_clr = c;
  endtask

  // Reference behaviour for one clock edge; expQ holds the accepted samples.
  task automatic modelStep();
    bit accept = in_valid && (expQ.size() < DEPTH);
    bit setU   = 1'b0;
    if (rst) begin
      mState = IDLE;
      mCount = 0;
      mDuty  = IDLE_DUTY;
      mUnder = 1'b0;
      expQ.delete();
      return;
    end
    case (mState)
      IDLE: if (en) mState = PRIME;
      PRIME: begin
        if (!en) mState = IDLE;
        else if (expQ.size() >= PRIME_LVL) begin
          mDuty  = expQ.pop_front();
          mState = RUN;
        end
      end
      default: begin
        if (!en) begin
          mState = IDLE;
          mDuty  = IDLE_DUTY;
          mCount = 0;
          expQ.delete();
          accept = 1'b0;
        end else if (mCount == 255) begin
          mCount = 0;
          if (expQ.size() > 0) mDuty = expQ.pop_front();
          else begin
            mUnder = 1'b1;
            setU   = 1'b1;
          end
        end else begin
          mCount++;
        end
      end
    endcase
    if (accept) expQ.push_back(int'(in_sample));
    if (underrun_clr && !setU) mUnder = 1'b0;
  endtask

  task automatic compareModel();
    checkOutput("model duty", duty, mDuty);
    checkOutput("model count", count, mCount);
    checkOutput("model underrun", underrun, mUnder);
    checkOutput("model fifo_level", fifo_level, expQ.size());
    checkOutput("model in_ready", in_ready, expQ.size() < DEPTH);
    checkOutput("model frame_start", frame_start, (mState == RUN) && (mCount == 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic runTo(input int target);
    int guard = 0;
    while (mCount != target && guard < 600) begin
      cycle();
      guard++;
    end
    if (guard >= 600) checkOutput("runTo budget", mCount, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 8'h00, 0, 128, 0, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h00, 0, 128, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h00, 0, 128, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 8'h00, 0, 128, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 8'hA1, 0, 128, 0, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 8'hA2, 0, 128, 0, 1, 2, 0, 0};
    vecs[6]  = '{0, 0, 1, 8'hA3, 0, 128, 0, 1, 3, 0, 0};
    vecs[7]  = '{0, 0, 1, 8'hA4, 0, 128, 0, 0, 4, 0, 0};
    vecs[8]  = '{0, 0, 1, 8'hA5, 0, 128, 0, 0, 4, 0, 0};
    vecs[9]  = '{0, 0, 0, 8'h00, 0, 128, 0, 0, 4, 0, 0};
    vecs[10] = '{0, 0, 0, 8'h00, 1, 128, 0, 0, 4, 0, 0};

    applyStimulus(1, 0, 0, 8'h00, 0);

    // Reset, idle and filling the FIFO against backpressure.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].sample, vecs[i].clr);
      cycle();
      checkOutput($sformatf("vec%0d duty", i), duty, vecs[i].eDuty);
      checkOutput($sformatf("vec%0d count", i), count, vecs[i].eCount);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, vecs[i].eReady);
      checkOutput($sformatf("vec%0d level", i), fifo_level, vecs[i].eLevel);
      checkOutput($sformatf("vec%0d underrun", i), underrun, vecs[i].eUnder);
      checkOutput($sformatf("vec%0d frame_start", i), frame_start, vecs[i].eFs);
    end

    // Enable with a full FIFO: prime, first pop, in_ready returns after the pop.
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle();
    checkOutput("prime full duty", duty, 128);
    checkOutput("prime full in_ready", in_ready, 0);
    cycle();
    checkOutput("drain first duty", duty, 8'hA1);
    checkOutput("drain first frame_start", frame_start, 1);
    checkOutput("drain first level", fifo_level, 3);
    checkOutput("drain in_ready rise", in_ready, 1);
    repeat (256) cycle();
    checkOutput("drain second duty", duty, 8'hA2);
    checkOutput("drain second level", fifo_level, 2);
    checkOutput("drain second frame_start", frame_start, 1);

    // Disable mid-frame at count 100 with three queued; same-cycle push is lost.
    applyStimulus(0, 1, 1, 8'hB0, 0);
    cycle();
    applyStimulus(0, 1, 0, 8'h00, 0);
    runTo(100);
    checkOutput("pre-disable level", fifo_level, 3);
    checkOutput("pre-disable count", count, 100);
    applyStimulus(0, 0, 1, 8'h55, 0);
    cycle();
    checkOutput("disable duty", duty, 128);
    checkOutput("disable count", count, 0);
    checkOutput("disable level", fifo_level, 0);
    checkOutput("disable frame_start", frame_start, 0);

    // Prime and start with 0x40, 0xC0.
    applyStimulus(0, 1, 1, 8'h40, 0);
    cycle();
    applyStimulus(0, 1, 1, 8'hC0, 0);
    cycle();
    checkOutput("primed level", fifo_level, 2);
    checkOutput("primed duty", duty, 128);
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle();
    checkOutput("start duty", duty, 8'h40);
    checkOutput("start count", count, 0);
    checkOutput("start frame_start", frame_start, 1);
    runTo(255);
    checkOutput("mid-frame duty held", duty, 8'h40);
    cycle();
    checkOutput("frame2 duty", duty, 8'hC0);
    checkOutput("frame2 frame_start", frame_start, 1);

    // Underrun: single 0x10 queued, two boundaries.
    applyStimulus(0, 1, 1, 8'h10, 0);
    cycle();
    applyStimulus(0, 1, 0, 8'h00, 0);
    runTo(255);
    cycle();
    checkOutput("underrun load duty", duty, 8'h10);
    checkOutput("underrun not yet", underrun, 0);
    runTo(255);
    cycle();
    checkOutput("underrun held duty", duty, 8'h10);
    checkOutput("underrun set", underrun, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    cycle();
    checkOutput("underrun cleared", underrun, 0);

    // Collision: push at an empty boundary with clear also asserted.
    applyStimulus(0, 1, 0, 8'h00, 0);
    runTo(255);
    applyStimulus(0, 1, 1, 8'h77, 1);
    cycle();
    checkOutput("collision underrun", underrun, 1);
    checkOutput("collision duty", duty, 8'h10);
    checkOutput("collision level", fifo_level, 1);
    applyStimulus(0, 1, 0, 8'h00, 0);
    runTo(255);
    cycle();
    checkOutput("collision load duty", duty, 8'h77);
    checkOutput("collision load level", fifo_level, 0);

    // en=0 leaves the sticky flag alone.
    applyStimulus(0, 0, 0, 8'h00, 0);
    cycle();
    checkOutput("idle underrun kept", underrun, 1);
    checkOutput("idle duty", duty, 128);

    // Reset in the middle of a frame.
    applyStimulus(0, 1, 1, 8'h21, 0);
    cycle();
    applyStimulus(0, 1, 1, 8'h22, 0);
    cycle();
    applyStimulus(0, 1, 1, 8'h23, 0);
    cycle();
    checkOutput("rerun duty", duty, 8'h21);
    applyStimulus(0, 1, 0, 8'h00, 0);
    runTo(30);
    applyStimulus(1, 1, 1, 8'h99, 0);
    cycle();
    checkOutput("rst duty", duty, 128);
    checkOutput("rst count", count, 0);
    checkOutput("rst level", fifo_level, 0);
    checkOutput("rst underrun", underrun, 0);
    checkOutput("rst frame_start", frame_start, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    cycle();
    checkOutput("post-rst in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
- Sequencing controller in front of the 8-bit PWM comparator datapath.
- Buffers incoming audio samples in a small FIFO (valid/ready) and owns the PWM frame counter.
- Updates the duty value only at frame boundaries, so the comparator never sees a mid-frame change.
- Handles priming, underrun and enable/disable.

Parameters:
- SAMPLE_W, 8: sample and duty width; frame length is 2^SAMPLE_W clocks.
- FIFO_DEPTH, 4: sample buffer entries; must be a power of two, at least 2.
- PRIME_LEVEL, 2: FIFO occupancy required before frames start; range 1..FIFO_DEPTH.
- IDLE_LEVEL, 128: duty driven while not running (midscale, silence).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  run enable
- in_sample  in  SAMPLE_W  sample from producer
- in_valid  in  1  in_sample valid
- in_ready  out  1  FIFO can accept; equals !full
- underrun_clr  in  1  clears sticky underrun flag
- duty  out  SAMPLE_W  registered duty value to the PWM comparator
- count  out  SAMPLE_W  registered frame counter; comparator drives high while count < duty
- frame_start  out  1  high for the single cycle where count==0 in RUN
- underrun  out  1  sticky: a frame boundary found the FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, duty=IDLE_LEVEL, count=0, underrun=0, FIFO empty (fifo_level=0, in_ready=1), frame_start=0.
- Push: occurs when in_valid && in_ready. Accepted in every state except during rst. Data is visible at head the next cycle; there is no bypass.
- IDLE:
  - count held 0; duty=IDLE_LEVEL.
  - en=1 -> PRIME.
- PRIME:
  - count held 0; duty=IDLE_LEVEL.
  - en=0 -> IDLE.
  - fifo_level >= PRIME_LEVEL -> RUN. On that transition edge: pop head into duty, count=0.
- RUN:
  - count increments by 1 each cycle, wrapping 2^SAMPLE_W-1 -> 0.
  - Frame boundary: the edge where count goes from max to 0.
    - FIFO non-empty: pop head into duty.
    - FIFO empty: duty holds its previous value, underrun<=1, state stays RUN.
  - Latency: a sample pushed at cycle t reaches duty at the first frame boundary after t+1 at which it is head.
  - en=0 -> IDLE on the next edge, regardless of count: duty=IDLE_LEVEL, count=0, FIFO flushed (level=0). Any push in that same cycle is discarded.
- Simultaneous push and pop: allowed; level unchanged. Push and pop at a boundary with the FIFO empty gives underrun, and the pushed sample stays in the FIFO.
- Full FIFO: in_ready=0; no push. A pop in that cycle does not raise in_ready until the next cycle (registered full).
- underrun:
  - Set has priority over underrun_clr in the same cycle.
  - Cleared only by underrun_clr or rst; it is not cleared by en=0.
- rst mid-frame: all state returns to reset values on the next edge; FIFO contents are lost.
- Widths: counter and duty are exactly SAMPLE_W bits; wrap is natural overflow. FIFO pointers are $clog2(FIFO_DEPTH) bits with a separate occupancy counter.

Decomposition:
- Shared package synth_pkg holds:
  - SAMPLE_W default constant
  - IDLE_LEVEL default
  - typedef sample_t (logic [SAMPLE_W-1:0])
  - enum sched_state_t {IDLE, PRIME, RUN}
- One sub-module, sample_fifo: synchronous FIFO with push/pop, full/empty, level, and flush.
- FSM, frame counter, duty register and underrun flag live in pwm_sample_scheduler.

Test Plan:
- Reset and idle: assert rst 3 cycles, en=0, in_valid=0 -> duty=128, count=0, in_ready=1, underrun=0, frame_start never high.
- Prime and start: en=1, push 0x40 and 0xC0 -> RUN entered the cycle after level hits 2. duty=0x40, count=0, frame_start=1. 256 cycles later duty=0xC0 and frame_start=1 again.
- Underrun: with one sample 0x10 queued and no further pushes, run two frames -> second boundary keeps duty=0x10 and sets underrun=1. Pulse underrun_clr -> underrun=0.
- Backpressure: en=0, push 5 samples with in_valid held high -> 4 accepted, in_ready=0 after the 4th, level=4. Enable -> FIFO drains one entry per 256 cycles, and in_ready rises the cycle after the first pop.
- Disable mid-frame: in RUN at count=100 with level=3, drop en -> next edge: state IDLE, duty=128, count=0, level=0.
- Collision: at a boundary with the FIFO empty, push 0x77 that same cycle -> underrun=1, duty unchanged, level=1. The next boundary loads duty=0x77.
